// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder:
//   - state_e      : responder FSM states (IDLE, WAIT, RESP)
//   - BE_*         : the byte-enable patterns a request may legally carry
//   - be_legal()   : 1 when a byte-enable pattern is one of the legal ones
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Single byte lanes, aligned halves and the full word.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_WD = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WD: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port word array with per-byte write enables. Read and write are both
// synchronous: when en_i is high a store updates the enabled lanes, a load
// captures the whole addressed word into the read register. The read register
// only changes on an enabled load, so it stays stable while a response waits.
// Contents are not reset.
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (read register only)
//   en_i     in   perform an access this edge
//   we_i     in   1 = store, 0 = load
//   be_i     in   byte-lane write enables (lane 0 = bits 7:0)
//   addr_i   in   word index
//   wdata_i  in   store data
//   rdata_o  out  last loaded word
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << WORD_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes into the storage array.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read register: captures the full word on an enabled load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0000_0000;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder end of the MEM-stage data request/response interface. Takes one
// load/store at a time, performs the word access LATENCY cycles after accept
// and presents read data plus an illegal-byte-enable flag until the initiator
// takes it. Intended to model a slow off-core RAM so pipeline stalls happen.
// Parameters:
//   ADDR_W   byte-address width; array holds 2**(ADDR_W-2) words
//   LATENCY  accept-to-rsp_valid cycles, 1..15
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata   store flag, byte address, lane-aligned data
//   req_be                        byte enables
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata                     loaded word; 0 for stores and errors
//   rsp_err                       request carried an illegal byte enable
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned WORD_W   = ADDR_W - 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    // With a one-cycle latency the access happens on the accept edge itself,
    // straight from the request inputs, and WAIT is skipped.
    localparam bit          DIRECT   = (LATENCY == 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_load_q, rsp_load_d;

    logic                access_s;
    logic                acc_we_s;
    logic [WORD_W-1:0]   acc_word_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    logic [BE_W-1:0]     acc_be_s;
    logic                acc_legal_s;
    logic                arr_en_s;
    logic [DATA_W-1:0]   arr_rdata_s;
    logic                unused_s;

    // Byte offset within the word plays no part in the access.
    assign unused_s = ^req_addr[1:0];

    // State and request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            word_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            be_q        <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // Next-state, request latch, access strobe and response flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_load_d  = rsp_load_q;
        access_s    = 1'b0;
        acc_we_s    = we_q;
        acc_word_s  = word_q;
        acc_wdata_s = wdata_q;
        acc_be_s    = be_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    word_d  = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_INIT;
                    if (DIRECT) begin
                        access_s    = 1'b1;
                        acc_we_s    = req_we;
                        acc_word_s  = req_addr[ADDR_W-1:2];
                        acc_wdata_s = req_wdata;
                        acc_be_s    = req_be;
                        state_d     = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // cnt holds the WAIT cycles still to run including this one;
                // the access fires on the edge that would take it to zero.
                if (cnt_q <= 4'd1) begin
                    access_s = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_load_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_load_d  = 1'b0;
                state_d     = IDLE;
            end
        endcase

        acc_legal_s = be_legal(acc_be_s);

        if (access_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !acc_legal_s;
            rsp_load_d  = acc_legal_s && !acc_we_s;
        end else begin
            rsp_load_d = rsp_load_d;
        end
    end

    // Illegal byte enables never touch the array.
    assign arr_en_s = access_s && acc_legal_s;

    dmem_array #(
        .WORD_W (WORD_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arr_en_s),
        .we_i    (acc_we_s),
        .be_i    (acc_be_s),
        .addr_i  (acc_word_s),
        .wdata_i (acc_wdata_s),
        .rdata_o (arr_rdata_s)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // Read register is only meaningful for a legal load; zero otherwise.
    assign rsp_rdata = rsp_load_q ? arr_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_1, req_ready_1, req_we_1;
    logic [11:0] req_addr_1;
    logic [31:0] req_wdata_1;
    logic [3:0]  req_be_1;
    logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic [31:0] rsp_rdata_1;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.ADDR_W(12), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(12), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_be(req_be_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
    );

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];
    logic [3:0] legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic logic legal(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // One full transaction on the LATENCY=2 instance; lat counts cycles from
    // the accept cycle (1 = valid in the very next cycle).
    task automatic txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er,
                       output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("req_ready_idle", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check1("rsp_valid_drop", rsp_valid, 1'b0);
        check1("req_ready_back", req_ready, 1'b1);
    endtask

    // Same transaction on the LATENCY=1 instance.
    task automatic txn1(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid_1 = 1'b1; req_we_1 = we; req_addr_1 = addr; req_wdata_1 = wd; req_be_1 = be;
        check1("l1_req_ready_idle", req_ready_1, 1'b1);
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        lat = 1;
        while (rsp_valid_1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata_1;
        er = rsp_err_1;
        rsp_ready_1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_1 = 1'b0;
        check1("l1_rsp_valid_drop", rsp_valid_1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] model [16];
        logic [15:0] a16;
        int          n;

        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 12'h010, 32'h0000_0000, 4'b1111, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 12'h012, 32'h00AB_0000, 4'b0100, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 12'h010, 32'h0000_0000, 4'b1111, 32'hDEABBEEF, 1'b0};
        vecs[4]  = '{1'b1, 12'h020, 32'hCAFEF00D, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 12'h020, 32'hFFFF_FFFF, 4'b0101, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 12'h020, 32'h0000_0000, 4'b1111, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b1, 12'h022, 32'h5566_0000, 4'b1100, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 12'h021, 32'h0000_0000, 4'b1111, 32'h5566F00D, 1'b0};
        vecs[9]  = '{1'b0, 12'h020, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 12'h030, 32'hA5A5A5A5, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, 12'h040, 32'h0123_4567, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 12'h013, 32'h0000_0000, 4'b0001, 32'hDEABBEEF, 1'b0};

        req_valid = 1'b0; req_we = 1'b0; req_addr = 12'h000; req_wdata = 32'h0; req_be = 4'b0000;
        rsp_ready = 1'b0;
        req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = 12'h000; req_wdata_1 = 32'h0;
        req_be_1 = 4'b0000; rsp_ready_1 = 1'b0;

        // Reset
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check1("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check1("reset_rsp_err", rsp_err, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("reset_req_ready", req_ready, 1'b1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check1($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Backpressure: response held 5 cycles, competing request ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_be = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check1("bp_rsp_valid", rsp_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040;
            req_wdata = 32'hBAD0BAD0; req_be = 4'b1111;
            @(posedge clk); #1;
            check1("bp_hold_valid", rsp_valid, 1'b1);
            check("bp_hold_rdata", rsp_rdata, 32'hDEABBEEF);
            check1("bp_req_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check1("bp_release", rsp_valid, 1'b0);
        txn(1'b0, 12'h040, 32'h0, 4'b1111, rd, er, lat);
        check("bp_no_store", rd, 32'h0123_4567);

        // Reset during WAIT drops the store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h030;
        req_wdata = 32'h1234_5678; req_be = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check1("rst_wait_valid", rsp_valid, 1'b0);
        check("rst_wait_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 12'h030, 32'h0, 4'b1111, rd, er, lat);
        check("rst_wait_old", rd, 32'hA5A5A5A5);

        // Reset during RESP clears outputs immediately
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_be = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_resp_before", rsp_rdata, 32'hDEABBEEF);
        #2 rst_n = 1'b0;
        #1;
        check1("rst_resp_valid", rsp_valid, 1'b0);
        check("rst_resp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // LATENCY=1 instance with address aliasing
        a16 = 16'h1004;
        txn1(1'b1, a16[11:0], 32'h0BADF00D, 4'b1111, rd, er, lat);
        check("l1_sw_latency", 32'(lat), 32'd1);
        txn1(1'b0, 12'h004, 32'h0, 4'b1111, rd, er, lat);
        check("l1_lw_rdata", rd, 32'h0BADF00D);
        check("l1_lw_latency", 32'(lat), 32'd1);
        txn1(1'b1, 12'h006, 32'h7788_0000, 4'b1100, rd, er, lat);
        txn1(1'b0, 12'h004, 32'h0, 4'b0001, rd, er, lat);
        check("l1_sh_rdata", rd, 32'h7788F00D);
        txn1(1'b0, 12'h004, 32'h0, 4'b0110, rd, er, lat);
        check("l1_bad_rdata", rd, 32'h0);
        check1("l1_bad_err", er, 1'b1);

        // Randomised traffic against a word-level memory model
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1'b1, 12'(12'h800 + 12'(i * 4)), model[i], 4'b1111, rd, er, lat);
            check("rnd_init_err", {31'd0, er}, 32'd0);
        end
        for (int k = 0; k < 120; k++) begin
            int          idx;
            logic        we;
            logic [3:0]  be;
            logic [31:0] wd, mask, exp_rd;
            logic        exp_err;
            logic [11:0] addr;
            idx  = $urandom_range(0, 15);
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            if ($urandom_range(0, 4) == 0) be = 4'($urandom_range(0, 15));
            else                           be = legal_list[$urandom_range(0, 6)];
            addr = 12'(12'h800 + 12'(idx * 4) + 12'($urandom_range(0, 3)));
            if (!legal(be)) begin
                exp_rd = 32'h0; exp_err = 1'b1;
            end else if (we) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model[idx] = (model[idx] & ~mask) | (wd & mask);
                exp_rd = 32'h0; exp_err = 1'b0;
            end else begin
                exp_rd = model[idx]; exp_err = 1'b0;
            end
            txn(we, addr, wd, be, rd, er, lat);
            check("rnd_rdata", rd, exp_rd);
            check1("rnd_err", er, exp_err);
            check("rnd_latency", 32'(lat), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
